// File: rtl/joy_db15_tx.sv
// Device-side DB15 joystick adapter: answers JOY_LOAD/JOY_CLK polling and shifts two pads out on JOY_DATA.
// Optional input glitch filter enabled by defining JOY_DB15_TX_FILTER_EN.
module joy_db15_tx #(
  parameter int NBITS = 24,
  parameter int FILT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] joystick1,
  input  logic [11:0] joystick2,
  input  logic        JOY_LOAD,
  input  logic        JOY_CLK,
  output logic        JOY_DATA,
  output logic        frame_done,
  output logic        overrun
);

  localparam int CW = $clog2(NBITS + 1);
  localparam int PW = (NBITS > 24) ? NBITS : 24;

  logic [1:0]       load_sync;
  logic [1:0]       clk_sync;
  logic             load_lvl;
  logic             clk_lvl;
  logic             clk_prev;
  logic             clk_rise;
  logic [NBITS-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             hit;
  logic [PW-1:0]    pads;
  logic [NBITS-1:0] load_vec;

  // Pads above bit 23 read as released; short frames keep the low-order buttons.
  assign pads     = PW'({joystick2, joystick1});
  assign load_vec = ~pads[NBITS-1:0];

  // Synchronisers idle high so a reset never looks like a load request or a clock edge.
  always_ff @(posedge clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      load_sync <= 2'b11;
      clk_sync  <= 2'b11;
    end else begin
      load_sync <= {load_sync[0], JOY_LOAD};
      clk_sync  <= {clk_sync[0], JOY_CLK};
    end
  end

`ifdef JOY_DB15_TX_FILTER_EN
  localparam int FW = $clog2(FILT + 1);
  logic [FW-1:0] load_fcnt;
  logic [FW-1:0] clk_fcnt;

  // A new level is adopted only after FILT consecutive samples disagree with the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      load_lvl  <= 1'b1;
      clk_lvl   <= 1'b1;
      load_fcnt <= '0;
      clk_fcnt  <= '0;
    end else begin
      if (load_sync[1] == load_lvl) begin
        load_fcnt <= '0;
      end else if (load_fcnt == FW'(FILT - 1)) begin
        load_lvl  <= load_sync[1];
        load_fcnt <= '0;
      end else begin
        load_fcnt <= load_fcnt + 1'b1;
      end

      if (clk_sync[1] == clk_lvl) begin
        clk_fcnt <= '0;
      end else if (clk_fcnt == FW'(FILT - 1)) begin
        clk_lvl  <= clk_sync[1];
        clk_fcnt <= '0;
      end else begin
        clk_fcnt <= clk_fcnt + 1'b1;
      end
    end
  end
`else
  assign load_lvl = load_sync[1];
  assign clk_lvl  = clk_sync[1];
`endif

  assign clk_rise = clk_lvl & ~clk_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_prev   <= 1'b1;
      sr         <= '1;
      JOY_DATA   <= 1'b1;
      cnt        <= '0;
      hit        <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      clk_prev   <= clk_lvl;
      JOY_DATA   <= sr[0];
      frame_done <= hit;
      hit        <= 1'b0;
      if (!load_lvl) begin
        // Load wins over any coincident edge; pads are resampled every cycle.
        sr      <= load_vec;
        cnt     <= '0;
        overrun <= 1'b0;
      end else if (clk_rise) begin
        sr <= {1'b1, sr[NBITS-1:1]};
        if (cnt == CW'(NBITS)) begin
          overrun <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
          hit <= (cnt == CW'(NBITS - 1));
        end
      end
    end
  end

endmodule
